// File: rtl/ir_sensor_intf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ir_sensor_intf_pkg
// Brief    : Shared types and constants for the IR sensor interface: the
//            sequencer state encoding, the A2D channel map and the open-side
//            hysteresis helper.
// Revision : 1.0 - initial release
// ============================================================================
package ir_sensor_intf_pkg;

    // Sequencer states for one left/right sample pass
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        CNV_L  = 3'd2,
        CNV_R  = 3'd3,
        CALC   = 3'd4
    } ir_state_t;

    // A2D mux channels wired to the left and right receivers
    localparam logic [2:0] LFT_CHNL  = 3'd1;
    localparam logic [2:0] RGHT_CHNL = 3'd0;

    // Hysteresis for the open-side flag: a weak reading sets it, a reading
    // clearly above threshold plus margin clears it, anything between holds.
    function automatic logic open_next(
        input logic [11:0] rd,
        input logic        prev,
        input logic [11:0] thres,
        input logic [11:0] hyst
    );
        logic [12:0] w_clr_lvl;
        w_clr_lvl = {1'b0, thres} + {1'b0, hyst};
        if (rd < thres)
            return 1'b1;
        else if ({1'b0, rd} > w_clr_lvl)
            return 1'b0;
        else
            return prev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ir_sensor_intf_dterm_calc.sv
`default_nettype none
// ============================================================================
// Module   : ir_dterm_calc
// Brief    : Derivative term of the left/right IR difference. Keeps the last
//            four differences, multiplies (diff - oldest) by D_COEFF and
//            saturates the product to a 9-bit signed result.
// Revision : 1.0 - initial release
// ============================================================================
module ir_dterm_calc #(
    parameter logic [3:0] D_COEFF = 4'd6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_calc,
    input  logic               i_force_zero,
    input  logic signed [12:0] i_diff,
    output logic signed [8:0]  o_dtrm
);

    // Index 0 is the newest difference, index 3 the oldest
    logic signed [12:0] r_hist [4];
    logic signed [13:0] w_dlt;
    logic signed [18:0] w_prod;
    logic signed [8:0]  w_sat;

    // Slope over four samples, scaled and clamped to the output range
    always_comb begin
        w_dlt  = $signed({i_diff[12], i_diff}) - $signed({r_hist[3][12], r_hist[3]});
        w_prod = $signed({{5{w_dlt[13]}}, w_dlt}) * $signed({15'd0, D_COEFF});
        if (w_prod > 19'sd255)
            w_sat = 9'sd255;
        else if (w_prod < -19'sd256)
            w_sat = -9'sd256;
        else
            w_sat = w_prod[8:0];
    end

    // History shift and result register; an open side pre-loads the history
    // so the first closed sample after it does not see a stale step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_dtrm <= '0;
            for (int i = 0; i < 4; i++)
                r_hist[i] <= '0;
        end else if (i_calc) begin
            if (i_force_zero) begin
                o_dtrm <= '0;
                for (int i = 0; i < 4; i++)
                    r_hist[i] <= i_diff;
            end else begin
                o_dtrm    <= w_sat;
                r_hist[0] <= i_diff;
                for (int i = 1; i < 4; i++)
                    r_hist[i] <= r_hist[i-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ir_sensor_intf.sv
`default_nettype none
// ============================================================================
// Module   : ir_sensor_intf
// Brief    : Periodically powers the IR emitters, converts left then right
//            receiver through the A2D, and publishes the readings, open-side
//            flags and a saturated derivative term with a one-cycle strobe.
// Revision : 1.0 - initial release
// ============================================================================
module ir_sensor_intf
    import ir_sensor_intf_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 1024,
    parameter int unsigned SMPL_PER   = 65536,
    parameter logic [11:0] OPN_THRES  = 12'h300,
    parameter logic [11:0] OPN_HYST   = 12'h080,
    parameter logic [3:0]  D_COEFF    = 4'd6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_IR,
    input  logic               cnv_cmplt,
    input  logic [11:0]        A2D_res,
    output logic               strt_cnv,
    output logic [2:0]         chnnl,
    output logic               IR_en,
    output logic signed [11:0] lft_IR,
    output logic signed [11:0] rght_IR,
    output logic               lft_opn,
    output logic               rght_opn,
    output logic signed [8:0]  IR_Dtrm,
    output logic               IR_vld
);

    localparam int TMR_W = (SMPL_PER   > 1) ? $clog2(SMPL_PER)   : 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(SMPL_PER - 1);
    localparam logic [SET_W-1:0] C_SET_LAST = SET_W'(SETTLE_CYC - 1);

    ir_state_t          r_state, w_state_nxt;
    logic [TMR_W-1:0]   r_timer;
    logic [SET_W-1:0]   r_settle_cnt;
    logic               w_tick;
    logic               r_abort, w_abort_nxt;
    logic               r_strt_cnv, w_strt_nxt;
    logic               w_cap_l, w_cap_r, w_calc;
    logic [11:0]        r_lft_shdw, r_rght_shdw;
    logic [11:0]        r_lft_ir, r_rght_ir;
    logic               r_lft_opn, r_rght_opn;
    logic               w_lft_opn_nxt, w_rght_opn_nxt;
    logic signed [12:0] w_diff;
    logic               r_vld;

    assign w_tick = (r_timer == C_TMR_LAST);
    assign w_calc = (r_state == CALC);

    // Free-running sample period timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_timer <= '0;
        else if (w_tick)
            r_timer <= '0;
        else
            r_timer <= r_timer + TMR_W'(1);
    end

    // Emitter settle counter, cleared whenever the sequencer leaves SETTLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_settle_cnt <= '0;
        else if (r_state == SETTLE)
            r_settle_cnt <= r_settle_cnt + SET_W'(1);
        else
            r_settle_cnt <= '0;
    end

    // Sequencer state, start pulse and sticky abort flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_strt_cnv <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_strt_cnv <= w_strt_nxt;
            r_abort    <= w_abort_nxt;
        end
    end

    // Next state: a dropped enable ends SETTLE at once, but an issued
    // conversion is always allowed to finish before returning to IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_strt_nxt  = 1'b0;
        w_abort_nxt = r_abort;
        w_cap_l     = 1'b0;
        w_cap_r     = 1'b0;
        case (r_state)
            IDLE: begin
                w_abort_nxt = 1'b0;
                if (w_tick && en_IR)
                    w_state_nxt = SETTLE;
            end
            SETTLE: begin
                if (!en_IR) begin
                    w_state_nxt = IDLE;
                end else if (r_settle_cnt == C_SET_LAST) begin
                    w_state_nxt = CNV_L;
                    w_strt_nxt  = 1'b1;
                end
            end
            CNV_L: begin
                if (!en_IR)
                    w_abort_nxt = 1'b1;
                if (cnv_cmplt) begin
                    if (r_abort || !en_IR) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cap_l     = 1'b1;
                        w_state_nxt = CNV_R;
                        w_strt_nxt  = 1'b1;
                    end
                end
            end
            CNV_R: begin
                if (!en_IR)
                    w_abort_nxt = 1'b1;
                if (cnv_cmplt) begin
                    if (r_abort || !en_IR) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cap_r     = 1'b1;
                        w_state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Emitter power and channel select follow the state directly
    always_comb begin
        IR_en = (r_state == SETTLE) || (r_state == CNV_L) || (r_state == CNV_R);
        chnnl = (r_state == CNV_L) ? LFT_CHNL : RGHT_CHNL;
    end

    // Shadow registers hold conversions until the whole pair is valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lft_shdw  <= '0;
            r_rght_shdw <= '0;
        end else begin
            if (w_cap_l)
                r_lft_shdw <= A2D_res;
            if (w_cap_r)
                r_rght_shdw <= A2D_res;
        end
    end

    // Open-side decisions and difference taken from the captured pair
    always_comb begin
        w_lft_opn_nxt  = open_next(r_lft_shdw,  r_lft_opn,  OPN_THRES, OPN_HYST);
        w_rght_opn_nxt = open_next(r_rght_shdw, r_rght_opn, OPN_THRES, OPN_HYST);
        w_diff         = $signed({1'b0, r_lft_shdw}) - $signed({1'b0, r_rght_shdw});
    end

    // Published readings and flags change together, flagged by IR_vld;
    // flags reset to open so downstream falls back to gyro-only steering
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lft_ir   <= '0;
            r_rght_ir  <= '0;
            r_lft_opn  <= 1'b1;
            r_rght_opn <= 1'b1;
            r_vld      <= 1'b0;
        end else begin
            r_vld <= w_calc;
            if (w_calc) begin
                r_lft_ir   <= r_lft_shdw;
                r_rght_ir  <= r_rght_shdw;
                r_lft_opn  <= w_lft_opn_nxt;
                r_rght_opn <= w_rght_opn_nxt;
            end
        end
    end

    ir_dterm_calc #(
        .D_COEFF (D_COEFF)
    ) u_dterm (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_calc       (w_calc),
        .i_force_zero (w_lft_opn_nxt | w_rght_opn_nxt),
        .i_diff       (w_diff),
        .o_dtrm       (IR_Dtrm)
    );

    assign strt_cnv = r_strt_cnv;
    assign lft_IR   = r_lft_ir;
    assign rght_IR  = r_rght_ir;
    assign lft_opn  = r_lft_opn;
    assign rght_opn = r_rght_opn;
    assign IR_vld   = r_vld;

endmodule
`default_nettype wire

// File: tb/tb_ir_sensor_intf.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_sensor_intf
// Brief    : Self-checking bench for ir_sensor_intf with a small A2D model,
//            a hand-derived vector table, corner sequences (aborts, reset
//            mid-conversion) and randomized samples against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ir_sensor_intf;

    localparam int THR  = 'h300;
    localparam int HYST = 'h080;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en_IR;
    logic               cnv_cmplt;
    logic [11:0]        A2D_res = '0;
    logic               strt_cnv;
    logic [2:0]         chnnl;
    logic               IR_en;
    logic signed [11:0] lft_IR, rght_IR;
    logic               lft_opn, rght_opn;
    logic signed [8:0]  IR_Dtrm;
    logic               IR_vld;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [11:0] lft_val = '0;
    logic [11:0] rght_val = '0;

    ir_sensor_intf #(
        .SETTLE_CYC (8),
        .SMPL_PER   (64),
        .OPN_THRES  (12'h300),
        .OPN_HYST   (12'h080),
        .D_COEFF    (4'd6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_IR     (en_IR),
        .cnv_cmplt (cnv_cmplt),
        .A2D_res   (A2D_res),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .IR_en     (IR_en),
        .lft_IR    (lft_IR),
        .rght_IR   (rght_IR),
        .lft_opn   (lft_opn),
        .rght_opn  (rght_opn),
        .IR_Dtrm   (IR_Dtrm),
        .IR_vld    (IR_vld)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A2D model: result 5 cycles after a start pulse, channel latched at start
    int          a2d_cnt = 0;
    logic [2:0]  a2d_ch  = '0;
    logic        a2d_done = 1'b0;
    logic        stray    = 1'b0;
    assign cnv_cmplt = a2d_done | stray;

    always @(negedge clk) begin
        a2d_done = 1'b0;
        if (strt_cnv) begin
            a2d_cnt = 5;
            a2d_ch  = chnnl;
        end else if (a2d_cnt > 0) begin
            a2d_cnt--;
            if (a2d_cnt == 0) begin
                a2d_done = 1'b1;
                A2D_res  = (a2d_ch == 3'd1) ? lft_val : rght_val;
            end
        end
    end

    // Reference model: readings as plain integers, history as a queue
    int m_hist[$];
    bit m_lo, m_ro;
    int m_l, m_r, m_d;

    task automatic model_reset();
        m_hist = {0, 0, 0, 0};
        m_lo = 1'b1; m_ro = 1'b1;
        m_l = 0; m_r = 0; m_d = 0;
    endtask

    task automatic model_step(input int l, input int r);
        int diff, p;
        if (l < THR) m_lo = 1'b1; else if (l > THR + HYST) m_lo = 1'b0;
        if (r < THR) m_ro = 1'b1; else if (r > THR + HYST) m_ro = 1'b0;
        m_l = l; m_r = r;
        diff = l - r;
        if (m_lo || m_ro) begin
            m_d = 0;
            m_hist = {diff, diff, diff, diff};
        end else begin
            p = (diff - m_hist[0]) * 6;
            m_d = (p > 255) ? 255 : ((p < -256) ? -256 : p);
            void'(m_hist.pop_front());
            m_hist.push_back(diff);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic wait_vld(input string nm, output int ok);
        ok = 0;
        for (int i = 0; i < 300 && ok == 0; i++) begin
            @(negedge clk);
            if (IR_vld) ok = 1;
        end
        if (ok == 0) chk({nm, "_vld_timeout"}, 0, 1);
    endtask

    task automatic wait_strt(input string nm, input logic [2:0] ch, output int ok);
        ok = 0;
        for (int i = 0; i < 300 && ok == 0; i++) begin
            @(negedge clk);
            if (strt_cnv && chnnl == ch) ok = 1;
        end
        if (ok == 0) chk({nm, "_strt_timeout"}, 0, 1);
    endtask

    task automatic chk_model(input string nm);
        chk({nm, "_lft_IR"},  int'(lft_IR),  m_l);
        chk({nm, "_rght_IR"}, int'(rght_IR), m_r);
        chk({nm, "_lft_opn"}, int'(lft_opn), int'(m_lo));
        chk({nm, "_rght_opn"}, int'(rght_opn), int'(m_ro));
        chk({nm, "_IR_Dtrm"}, int'(IR_Dtrm), m_d);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_lft_IR"},   int'(lft_IR),   0);
        chk({nm, "_rght_IR"},  int'(rght_IR),  0);
        chk({nm, "_IR_Dtrm"},  int'(IR_Dtrm),  0);
        chk({nm, "_lft_opn"},  int'(lft_opn),  1);
        chk({nm, "_rght_opn"}, int'(rght_opn), 1);
        chk({nm, "_IR_vld"},   int'(IR_vld),   0);
        chk({nm, "_IR_en"},    int'(IR_en),    0);
        chk({nm, "_strt_cnv"}, int'(strt_cnv), 0);
        chk({nm, "_chnnl"},    int'(chnnl),    0);
    endtask

    typedef struct {
        int l;
        int r;
        bit lo;
        bit ro;
        int d;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int ok, c0, c1, vld_cyc, prev_vld_cyc, n_vld, n_strt;
        logic [11:0] hold_l, hold_r;

        // Hand-derived sequence: open hysteresis, 4 flat samples then a
        // +20 step, saturation both ways, threshold edge values
        tbl[0]  = '{'h200, 'h500, 1'b1, 1'b0, 0};
        tbl[1]  = '{'h340, 'h500, 1'b1, 1'b0, 0};
        tbl[2]  = '{'h390, 'h500, 1'b0, 1'b0, 255};
        tbl[3]  = '{'h400, 'h400, 1'b0, 1'b0, 255};
        tbl[4]  = '{'h400, 'h400, 1'b0, 1'b0, 255};
        tbl[5]  = '{'h400, 'h400, 1'b0, 1'b0, 255};
        tbl[6]  = '{'h400, 'h400, 1'b0, 1'b0, 255};
        tbl[7]  = '{'h414, 'h400, 1'b0, 1'b0, 120};
        tbl[8]  = '{'h478, 'h400, 1'b0, 1'b0, 255};
        tbl[9]  = '{'h400, 'h464, 1'b0, 1'b0, -256};
        tbl[10] = '{'h400, 'h464, 1'b0, 1'b0, -256};
        tbl[11] = '{'h100, 'h400, 1'b1, 1'b0, 0};
        tbl[12] = '{'h381, 'h400, 1'b0, 1'b0, 255};
        tbl[13] = '{'h380, 'h2FF, 1'b0, 1'b1, 0};
        tbl[14] = '{'h380, 'h300, 1'b0, 1'b1, 0};
        tbl[15] = '{'h380, 'h380, 1'b0, 1'b1, 0};
        tbl[16] = '{'h380, 'h381, 1'b0, 1'b0, -6};

        rst_n = 1'b0;
        en_IR = 1'b1;
        model_reset();
        lft_val  = 12'(tbl[0].l);
        rght_val = 12'(tbl[0].r);
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");

        // Startup timing
        rst_n = 1'b1;
        c0 = cyc;
        ok = 0;
        for (int i = 0; i < 200 && ok == 0; i++) begin
            @(negedge clk);
            if (IR_en) ok = 1;
        end
        chk("first_tick_IR_en_seen", ok, 1);
        chk("first_tick_latency", cyc - c0, 64);
        c1 = cyc;
        wait_strt("settle", 3'd1, ok);
        chk("settle_len", cyc - c1, 8);
        chk("pre_calc_lft_opn", int'(lft_opn), 1);
        chk("pre_calc_rght_opn", int'(rght_opn), 1);
        @(negedge clk);
        chk("strt_cnv_one_cycle", int'(strt_cnv), 0);
        chk("chnnl_held_left", int'(chnnl), 1);
        chk("IR_en_in_cnv", int'(IR_en), 1);
        wait_strt("right_start", 3'd0, ok);

        // Table-driven samples
        prev_vld_cyc = 0;
        for (int i = 0; i < 17; i++) begin
            if (i > 0) begin
                lft_val  = 12'(tbl[i].l);
                rght_val = 12'(tbl[i].r);
            end
            wait_vld($sformatf("tbl%0d", i), ok);
            vld_cyc = cyc;
            model_step(tbl[i].l, tbl[i].r);
            chk($sformatf("tbl%0d_lft_IR", i),   int'(lft_IR),   tbl[i].l);
            chk($sformatf("tbl%0d_rght_IR", i),  int'(rght_IR),  tbl[i].r);
            chk($sformatf("tbl%0d_lft_opn", i),  int'(lft_opn),  int'(tbl[i].lo));
            chk($sformatf("tbl%0d_rght_opn", i), int'(rght_opn), int'(tbl[i].ro));
            chk($sformatf("tbl%0d_IR_Dtrm", i),  int'(IR_Dtrm),  tbl[i].d);
            if (i == 1) chk("vld_period", vld_cyc - prev_vld_cyc, 64);
            prev_vld_cyc = vld_cyc;
            @(negedge clk);
            chk($sformatf("tbl%0d_vld_one_cycle", i), int'(IR_vld), 0);
        end

        // en_IR dropped in SETTLE: emitters off on the next cycle
        ok = 0;
        for (int i = 0; i < 200 && ok == 0; i++) begin
            @(negedge clk);
            if (IR_en) ok = 1;
        end
        chk("settle_abort_seen", ok, 1);
        en_IR = 1'b0;
        @(negedge clk);
        chk("settle_abort_IR_en", int'(IR_en), 0);
        n_vld = 0; n_strt = 0;
        repeat (20) begin
            @(negedge clk);
            if (IR_vld) n_vld++;
            if (strt_cnv) n_strt++;
        end
        chk("settle_abort_no_vld", n_vld, 0);
        chk("settle_abort_no_strt", n_strt, 0);
        en_IR = 1'b1;

        // en_IR dropped in CNV_L: left conversion finishes, no right start
        hold_l = 12'h6A0; hold_r = 12'h650;
        lft_val = hold_l; rght_val = hold_r;
        wait_strt("cnvl_abort", 3'd1, ok);
        @(negedge clk);
        en_IR = 1'b0;
        @(negedge clk);
        chk("cnvl_abort_chnnl_held", int'(chnnl), 1);
        chk("cnvl_abort_IR_en_held", int'(IR_en), 1);
        n_vld = 0; n_strt = 0;
        repeat (80) begin
            @(negedge clk);
            if (IR_vld) n_vld++;
            if (strt_cnv) n_strt++;
        end
        chk("cnvl_abort_no_vld", n_vld, 0);
        chk("cnvl_abort_no_right_strt", n_strt, 0);
        chk("cnvl_abort_IR_en_off", int'(IR_en), 0);
        chk_model("cnvl_abort_hold");
        en_IR = 1'b1;
        wait_vld("post_abort", ok);
        model_step(int'(hold_l), int'(hold_r));
        chk_model("post_abort");

        // Randomized samples against the reference model
        for (int i = 0; i < 30; i++) begin
            int l, r;
            l = int'($urandom_range(12'h2C0, 12'h7FF));
            if ($urandom_range(0, 1) == 1) begin
                r = l + int'($urandom_range(0, 60)) - 30;
                if (r > 'h7FF) r = 'h7FF;
            end else begin
                r = int'($urandom_range(12'h2C0, 12'h7FF));
            end
            lft_val = 12'(l); rght_val = 12'(r);
            wait_vld($sformatf("rnd%0d", i), ok);
            model_step(l, r);
            chk_model($sformatf("rnd%0d", i));
            @(negedge clk);
        end

        // Reset during CNV_R, late completion and a stray pulse afterwards
        lft_val = 12'h500; rght_val = 12'h520;
        wait_strt("rst_cnvr", 3'd0, ok);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outs("in_reset");
        rst_n = 1'b1;
        model_reset();
        repeat (10) @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (5) @(negedge clk);
        chk_reset_outs("after_stray");
        for (int i = 0; i < 3; i++) begin
            wait_vld($sformatf("post_rst%0d", i), ok);
            model_step('h500, 'h520);
            chk_model($sformatf("post_rst%0d", i));
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
